// File: rtl/frame_stream_merger_pkg.sv
// frame_stream_merger_pkg: frame-format tags shared with the frame generator and merger FSM states
package frame_stream_merger_pkg;
  localparam logic [7:0] HEADER_TAG = 8'hAA;
  localparam logic [7:0] FOOTER_TAG = 8'h55;
  localparam int TAG_MSB = 63;
  localparam int TAG_LSB = 56;
  typedef enum logic {IDLE, FORWARD} state_t;
endpackage

// File: rtl/frame_stream_merger_axis_reg_slice.sv
// frame_stream_merger_axis_reg_slice: one-deep AXI-Stream output register that holds while stalled
module frame_stream_merger_axis_reg_slice #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [W-1:0] in_data,
  input  logic         tready,
  output logic         out_free,
  output logic         tvalid,
  output logic         tlast,
  output logic [W-1:0] tdata
);
  assign out_free = ~tvalid | tready;
  always_ff @(posedge clk)
    if (rst) begin
      tvalid <= 1'b0;
      tlast <= 1'b0;
      tdata <= '0;
    end else if (out_free) begin
      tvalid <= in_valid;
      tlast <= in_valid & in_last;
      if (in_valid) tdata <= in_data;
    end
endmodule

// File: rtl/frame_stream_merger.sv
// frame_stream_merger: round-robin, frame-granular merge of per-channel frame streams onto one AXI-Stream master
module frame_stream_merger
  import frame_stream_merger_pkg::*;
#(
  parameter int         CH_NUM          = 2,
  parameter int         DATA_WIDTH      = 64,
  parameter logic [7:0] HEADER_ID       = HEADER_TAG,
  parameter logic [7:0] FOOTER_ID       = FOOTER_TAG,
  parameter int         MAX_FRAME_WORDS = 256,
  parameter int         DROP_CNT_WIDTH  = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [CH_NUM*DATA_WIDTH-1:0] DIN,
  input  logic [CH_NUM-1:0]            iVALID,
  output logic [CH_NUM-1:0]            oREADY,
  output logic [DATA_WIDTH-1:0]        M_AXIS_TDATA,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic                         M_AXIS_TLAST,
  output logic [2:0]                   CUR_CH,
  output logic [DROP_CNT_WIDTH-1:0]    DROP_CNT,
  output logic                         OVERRUN
);
  localparam int CW = $clog2(MAX_FRAME_WORDS + 1);
  state_t state;
  logic held, out_free, sc_found, st_found, gnt_ok, fwd_acc, is_ftr, wd, in_valid, in_last;
  logic [2:0] rr, sc_ch, st_ch, g, sel, idx;
  logic [CW-1:0] word_cnt, nxt_cnt;
  logic [7:0] vld, hdr, stray;
  logic [CH_NUM-1:0] rdy;
  logic [DATA_WIDTH-1:0] w [8];
  assign vld = 8'(iVALID);
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < CH_NUM) begin : g_on
      assign w[i] = DIN[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_off
      assign w[i] = '0;
    end
    assign hdr[i] = vld[i] & (w[i][TAG_MSB:TAG_LSB] == HEADER_ID);
    assign stray[i] = vld[i] & ~hdr[i];
  end
  // descending loops so the last hit is the highest-priority candidate
  always_comb begin
    sc_found = 1'b0;
    sc_ch = '0;
    idx = '0;
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = 3'((int'(rr) + k) % CH_NUM);
      if (hdr[idx]) begin
        sc_found = 1'b1;
        sc_ch = idx;
      end
    end
    st_found = 1'b0;
    st_ch = '0;
    for (int k = 7; k >= 0; k--)
      if (stray[k]) begin
        st_found = 1'b1;
        st_ch = 3'(k);
      end
  end
  assign g = held ? CUR_CH : sc_ch;
  assign gnt_ok = held ? hdr[CUR_CH] : sc_found;
  assign sel = state == FORWARD ? CUR_CH : g;
  assign is_ftr = w[sel][TAG_MSB:TAG_LSB] == FOOTER_ID;
  assign nxt_cnt = word_cnt + 1'b1;
  assign wd = nxt_cnt == CW'(MAX_FRAME_WORDS);
  assign fwd_acc = state == FORWARD & vld[CUR_CH] & out_free;
  assign in_valid = state == FORWARD ? fwd_acc : gnt_ok & out_free;
  assign in_last = state == FORWARD & (is_ftr | wd);
  assign rdy = state == FORWARD ? CH_NUM'(out_free) << CUR_CH
             : (CH_NUM'(st_found) << st_ch) | (CH_NUM'(gnt_ok & out_free) << g);
  assign oREADY = RESET ? '0 : rdy;
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      rr <= 3'(CH_NUM - 1);
      CUR_CH <= '0;
      held <= 1'b0;
      word_cnt <= '0;
      DROP_CNT <= '0;
      OVERRUN <= 1'b0;
    end else if (state == IDLE) begin
      if (st_found && ~&DROP_CNT) DROP_CNT <= DROP_CNT + 1'b1;
      if (gnt_ok) CUR_CH <= g;
      held <= gnt_ok & ~out_free;
      if (gnt_ok & out_free) begin
        state <= FORWARD;
        word_cnt <= CW'(1);
      end
    end else if (fwd_acc) begin
      word_cnt <= nxt_cnt;
      if (is_ftr | wd) begin
        state <= IDLE;
        rr <= CUR_CH;
      end
      if (wd & ~is_ftr) OVERRUN <= 1'b1;
    end
  frame_stream_merger_axis_reg_slice #(.W(DATA_WIDTH)) u_out (
    .clk(CLK),
    .rst(RESET),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_data(w[sel]),
    .tready(M_AXIS_TREADY),
    .out_free(out_free),
    .tvalid(M_AXIS_TVALID),
    .tlast(M_AXIS_TLAST),
    .tdata(M_AXIS_TDATA)
  );
endmodule

// File: tb/tb_frame_stream_merger.sv
// tb_frame_stream_merger: frame-level reference model plus directed scenarios for the merger
module tb_frame_stream_merger;
  import frame_stream_merger_pkg::*;
  localparam int CH = 2;
  localparam logic [3:0] PAT = 4'b1001;
  logic clk = 1'b0;
  logic rst, tready, sel4, stall_chk;
  logic [CH*64-1:0] din;
  logic [CH-1:0] ivalid, ordy, ordy_a, ordy_b, acc;
  logic [63:0] td, td_a, td_b;
  logic tv, tv_a, tv_b, tl, tl_a, tl_b, ov, ov_a, ov_b;
  logic [2:0] cc, cc_a, cc_b;
  logic [15:0] dc, dc_a, dc_b;
  logic [63:0] in_q [CH][$];
  logic [64:0] exp_q [$];
  int hdr_seq [$];
  int total = 0, bad = 0, ncyc = 0;
  int mdrop, mrr, out_n, tl_n, hdr_at, first_tv;
  int acc_n [CH];
  bit mover;

  assign ordy = sel4 ? ordy_b : ordy_a;
  assign td = sel4 ? td_b : td_a;
  assign tv = sel4 ? tv_b : tv_a;
  assign tl = sel4 ? tl_b : tl_a;
  assign cc = sel4 ? cc_b : cc_a;
  assign dc = sel4 ? dc_b : dc_a;
  assign ov = sel4 ? ov_b : ov_a;

  frame_stream_merger #(.CH_NUM(CH)) dut (
    .CLK(clk), .RESET(rst), .DIN(din), .iVALID(ivalid), .oREADY(ordy_a),
    .M_AXIS_TDATA(td_a), .M_AXIS_TVALID(tv_a), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tl_a),
    .CUR_CH(cc_a), .DROP_CNT(dc_a), .OVERRUN(ov_a)
  );
  frame_stream_merger #(.CH_NUM(CH), .MAX_FRAME_WORDS(4)) dut4 (
    .CLK(clk), .RESET(rst), .DIN(din), .iVALID(ivalid), .oREADY(ordy_b),
    .M_AXIS_TDATA(td_b), .M_AXIS_TVALID(tv_b), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tl_b),
    .CUR_CH(cc_b), .DROP_CNT(dc_b), .OVERRUN(ov_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic apply();
    for (int c = 0; c < CH; c++) begin
      ivalid[c] = in_q[c].size() > 0;
      din[c*64 +: 64] = ivalid[c] ? in_q[c][0] : 64'h0;
    end
    tready = stall_chk ? PAT[ncyc % 4] : 1'b1;
  endtask

  function automatic bit busy();
    busy = exp_q.size() > 0 || tv === 1'b1;
    for (int c = 0; c < CH; c++) if (in_q[c].size() > 0) busy = 1'b1;
  endfunction

  task automatic push_frame(input int c, input int id, input int nd, input bit ftr);
    in_q[c].push_back({HEADER_TAG, 8'(c), 8'(id), 40'h0});
    for (int i = 1; i <= nd; i++) in_q[c].push_back({8'h00, 8'(c), 8'(id), 40'(i)});
    if (ftr) in_q[c].push_back({FOOTER_TAG, 8'(c), 8'(id), 40'hF});
  endtask

  // frame-level reference: strip strays, pick the next channel after the last winner, emit up to footer or limit
  task automatic model(input int maxw);
    logic [63:0] m [CH][$];
    logic [63:0] w;
    int c, n;
    bit any, l;
    for (int k = 0; k < CH; k++) m[k] = in_q[k];
    forever begin
      for (int k = 0; k < CH; k++)
        while (m[k].size() > 0 && m[k][0][63:56] != HEADER_TAG) begin
          void'(m[k].pop_front());
          mdrop++;
        end
      any = 0;
      c = 0;
      for (int k = 1; k <= CH; k++)
        if (!any && m[(mrr + k) % CH].size() > 0) begin
          any = 1;
          c = (mrr + k) % CH;
        end
      if (!any) break;
      n = 0;
      do begin
        w = m[c].pop_front();
        n++;
        l = w[63:56] == FOOTER_TAG || n == maxw;
        if (l && w[63:56] != FOOTER_TAG) mover = 1;
        exp_q.push_back({l, w});
      end while (!l && m[c].size() > 0);
      mrr = c;
    end
  endtask

  task automatic clear_model();
    mdrop = 0;
    mover = 0;
    mrr = CH - 1;
    out_n = 0;
    tl_n = 0;
    hdr_seq.delete();
    for (int c = 0; c < CH; c++) acc_n[c] = 0;
    hdr_at = -1;
    first_tv = -1;
  endtask

  task automatic do_reset(input bit w4);
    @(posedge clk);
    #2;
    rst = 1;
    sel4 = w4;
    for (int c = 0; c < CH; c++) in_q[c].delete();
    exp_q.delete();
    apply();
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    clear_model();
  endtask

  task automatic drain(input int maxw);
    int i;
    model(maxw);
    apply();
    i = 0;
    while (busy() && i < 400) begin
      @(posedge clk);
      #2;
      i++;
    end
    total++;
    if (busy()) begin
      bad++;
      $display("FAIL drain_timeout actual=busy required=idle");
    end
    repeat (4) @(posedge clk);
    #2;
    chk("drop_cnt", 64'(dc), 64'(mdrop));
    chk("overrun", 64'(ov), 64'(mover));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++)
      if (acc[c]) begin
        void'(in_q[c].pop_front());
        acc_n[c]++;
      end
    apply();
  end

  initial begin
    logic [63:0] pd;
    logic [64:0] e;
    logic pv, pl;
    pv = 0;
    pl = 0;
    pd = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      acc = ivalid & ordy;
      if (acc[0] && din[63:56] == HEADER_TAG && hdr_at < 0) hdr_at = ncyc;
      if (tv === 1'b1 && first_tv < 0) first_tv = ncyc;
      if (!rst && pv) begin
        chk("hold_valid", 64'(tv), 64'(1));
        chk("hold_data", td, pd);
        chk("hold_last", 64'(tl), 64'(pl));
      end
      if (stall_chk && tv && !tready) chk("stall_ready", 64'(ordy[cc[0]]), 64'(0));
      if (tv === 1'b1 && tready) begin
        out_n++;
        if (tl) tl_n++;
        if (td[63:56] == HEADER_TAG) hdr_seq.push_back(int'(td[55:48]));
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word actual=%h required=none", td);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", td, e[63:0]);
          chk("tlast", 64'(tl), 64'(e[64]));
        end
      end
      pv = !rst && tv === 1'b1 && !tready;
      pd = td;
      pl = tl;
    end
  end

  initial begin
    int i;
    rst = 1;
    sel4 = 0;
    stall_chk = 0;
    tready = 1;
    ivalid = '0;
    din = '0;
    acc = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_tvalid", 64'(tv), 64'(0));
    chk("rst_tlast", 64'(tl), 64'(0));
    chk("rst_tdata", td, 64'(0));
    chk("rst_oready", 64'(ordy), 64'(0));
    chk("rst_drop", 64'(dc), 64'(0));
    chk("rst_overrun", 64'(ov), 64'(0));
    chk("rst_cur_ch", 64'(cc), 64'(0));
    rst = 0;
    // single frame on ch0
    do_reset(0);
    push_frame(0, 1, 3, 1);
    drain(256);
    chk("t1_words", 64'(out_n), 64'(5));
    chk("t1_tlast_n", 64'(tl_n), 64'(1));
    chk("t1_latency", 64'(first_tv - hdr_at), 64'(1));
    // simultaneous headers, two frames per channel
    do_reset(0);
    push_frame(0, 1, 2, 1);
    push_frame(0, 2, 2, 1);
    push_frame(1, 1, 3, 1);
    push_frame(1, 2, 1, 1);
    drain(256);
    chk("t2_frames", 64'(hdr_seq.size()), 64'(4));
    if (hdr_seq.size() == 4) begin
      chk("t2_order0", 64'(hdr_seq[0]), 64'(0));
      chk("t2_order1", 64'(hdr_seq[1]), 64'(1));
      chk("t2_order2", 64'(hdr_seq[2]), 64'(0));
      chk("t2_order3", 64'(hdr_seq[3]), 64'(1));
    end
    // downstream stalls 1,0,0,1
    do_reset(0);
    stall_chk = 1;
    push_frame(0, 3, 6, 1);
    drain(256);
    stall_chk = 0;
    chk("t3_words", 64'(out_n), 64'(8));
    chk("t3_tlast_n", 64'(tl_n), 64'(1));
    // stray words while idle
    do_reset(0);
    in_q[1].push_back({8'h00, 8'd1, 8'd9, 40'h1});
    in_q[1].push_back({8'h12, 8'd1, 8'd9, 40'h2});
    drain(256);
    chk("t4_drop", 64'(dc), 64'(2));
    chk("t4_words", 64'(out_n), 64'(0));
    // watchdog truncation with a 4-word limit
    do_reset(1);
    push_frame(0, 5, 5, 0);
    drain(4);
    chk("t5_words", 64'(out_n), 64'(4));
    chk("t5_tlast_n", 64'(tl_n), 64'(1));
    chk("t5_overrun", 64'(ov), 64'(1));
    chk("t5_drop", 64'(dc), 64'(2));
    // reset after the second word of a frame
    do_reset(0);
    push_frame(0, 6, 3, 1);
    push_frame(0, 7, 1, 1);
    model(256);
    apply();
    i = 0;
    while (acc_n[0] < 2 && i < 50) begin
      @(posedge clk);
      #2;
      i++;
    end
    chk("t6_two_accepted", 64'(acc_n[0]), 64'(2));
    rst = 1;
    @(posedge clk);
    #2;
    chk("t6_tvalid", 64'(tv), 64'(0));
    chk("t6_oready", 64'(ordy), 64'(0));
    chk("t6_drop", 64'(dc), 64'(0));
    exp_q.delete();
    rst = 0;
    clear_model();
    drain(256);
    chk("t6_drop_after", 64'(dc), 64'(3));
    chk("t6_words", 64'(out_n), 64'(3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
